spi_mem_loader: RTL and testbench
=================================

# spi_mem_loader

SPI responder that gives an external host direct word access to the CPU's unified word-addressed memory, the hardware counterpart of the simulation-time hex image load. It sits between the board SPI pins and the memory write/read port muxed in front of the memory stage. While a frame is active it holds the CPU in reset so the host can write a program image and, optionally, read memory back for checking.

## Interface
Parameters:
- ADDR_W, 12, memory word-address width (4096 words; .text at 0, .data at 2048).
- DATA_W, 32, memory word width; fixed at 32 by the frame format.

Ports:
- clk  input  1  system clock; all logic in this domain.
- reset  input  1  asynchronous, active-low reset.
- sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
- cs_n  input  1  SPI chip select, active low.
- mosi  input  1  host-to-block serial data, MSB first.
- miso  output  1  block-to-host serial data, MSB first.
- mem_addr  output  ADDR_W  word address to memory.
- mem_wdata  output  32  write data.
- mem_we  output  1  one-clk write strobe.
- mem_re  output  1  one-clk read strobe.
- mem_rdata  input  32  read data, valid the clk after mem_re.
- cpu_hold  output  1  high while a frame is in progress; ORed into CPU reset.

## Operation
- sclk, cs_n, mosi pass through 2-flop synchronizers; rising/falling sclk edges detected on synchronized value.
- Frame (cs_n low): 8-bit command, 16-bit byte-agnostic word address (low ADDR_W bits used), then N 32-bit data words.
- Commands: 0x02 WRITE, 0x03 READ; anything else -> IGNORE.
- FSM: IDLE -> CMD (cs_n falls) -> ADDR (8 bits received) -> WDATA or RDATA (16 address bits received) or IGNORE; any state -> IDLE when cs_n rises.
- WDATA: shift mosi on sclk rising; on 32nd bit pulse mem_we with mem_addr/mem_wdata stable; mem_addr increments the clk after the strobe.
- RDATA: mem_re pulsed the clk after the last address bit, and the clk after each word's 32nd bit; mem_rdata loaded into shift register next clk; miso driven from shift MSB, advanced on sclk falling; mem_addr increments after each mem_re.
- IGNORE: no memory strobes, miso 0 until cs_n high.
- Address increment wraps from 2^ADDR_W-1 to 0.
- cs_n rise mid-word: partial word discarded, no strobe, bit counter cleared.
- cpu_hold = synchronized cs_n low; drops the clk cs_n-high is seen.

## Timing
- All outputs reset to 0; state IDLE; counters 0.
- Input-to-detection latency: 3 clk (2 sync + edge register).
- mem_we: asserted 1 clk after the 32nd rising edge is detected (4 clk after pin edge), width exactly 1 clk.
- Read: mem_re -> mem_rdata sampled next clk -> shift register loaded the clk after that.
- Requirement on host: sclk high and low phases each ≥ 8 clk; ≥ 8 clk from cs_n fall to first sclk rise and from last sclk fall to cs_n rise.
- miso changes only in the clk after a detected falling edge or a shift-register load; 0 when cs_n high.
- Reset asserted mid-frame: immediate return to IDLE, strobes drop asynchronously, no partial write.

## Configuration
- SPI_LOADER_READBACK_EN defined: READ (0x03) supported as above.
- Undefined: 0x03 handled as an unknown command (IGNORE); mem_re tied 0, miso tied 0; read path logic removed.

## Test plan
- Reset: hold reset low, toggle sclk/cs_n -> all outputs 0, no strobes.
- WRITE 0x02, addr 0x0000, words 0x20080005, 0x2009000A -> mem_we pulses twice, addr 0/1, data matching; cpu_hold high for frame only.
- WRITE at addr 0x0FFF, two words -> second write lands at address 0 (wrap).
- WRITE frame, cs_n raised after 20 bits of second word -> exactly one mem_we, FSM IDLE, next frame works.
- READ 0x03 addr 0x0800 with memory 0xDEADBEEF, 0x12345678 (READBACK_EN) -> miso streams those words MSB first; without macro -> miso 0, no mem_re.
- Command 0x55 followed by 48 bits -> no mem_we/mem_re, miso 0.

Source files
------------

// File: rtl/spi_mem_loader_if.sv
// -----------------------------------------------------------------------------
// spi_mem_loader_if
// Memory-side word port of the SPI memory loader. The loader drives the
// address, write data and strobes through the master modport; the memory
// (or the mux in front of the memory stage) connects through the slave
// modport and returns read data one clk after mem_re.
//
// Signals:
//   mem_addr   word address
//   mem_wdata  write data
//   mem_we     one-clk write strobe
//   mem_re     one-clk read strobe
//   mem_rdata  read data, valid the clk after mem_re
// -----------------------------------------------------------------------------
interface spi_mem_loader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output mem_re,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  mem_re,
    output mem_rdata
  );
endinterface

// File: rtl/spi_mem_loader.sv
// -----------------------------------------------------------------------------
// spi_mem_loader
// SPI mode-0 responder giving an external host word access to the CPU's
// unified memory. Frame (cs_n low): 8-bit command, 16-bit word address
// (low ADDR_W bits used), then any number of 32-bit words, MSB first.
//   0x02 WRITE : each received word is written, address auto-increments.
//   0x03 READ  : words are streamed out on miso (only with readback build).
//   other      : ignored until cs_n rises.
// The CPU is held in reset (cpu_hold) while a frame is in progress.
//
// Build option: define SPI_LOADER_READBACK_EN to include the READ path.
// Without it, 0x03 is treated as an unknown command, mem_re and miso are 0.
//
// Ports:
//   clk       system clock
//   reset     asynchronous active-low reset
//   sclk      SPI clock (asynchronous to clk)
//   cs_n      SPI chip select, active low
//   mosi      host-to-block serial data
//   miso      block-to-host serial data
//   cpu_hold  high while a frame is active; ORed into CPU reset
//   mem       memory port (spi_mem_loader_if master)
// -----------------------------------------------------------------------------
module spi_mem_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sclk,
  input  logic               cs_n,
  input  logic               mosi,
  output logic               miso,
  output logic               cpu_hold,
  spi_mem_loader_if.master   mem
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_RDATA,
    S_IGNORE
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  state_t state_q, state_d;

  logic sclk_s1_q, sclk_s2_q, sclk_prev_q;
  logic cs_s1_q, cs_s2_q;
  logic mosi_s1_q, mosi_s2_q;
  logic rise_q;

  logic [5:0]        cnt_q, cnt_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [31:0]       rx_sh_q, rx_sh_d;
  logic [31:0]       rx_next;

  assign rx_next = {rx_sh_q[30:0], mosi_s2_q};

`ifdef SPI_LOADER_READBACK_EN
  logic        fall_q;
  logic        re_q, re_d;
  logic        rd_pend_q, rd_pend_d;
  logic        shift_ok_q, shift_ok_d;
  logic        miso_q, miso_d;
  logic [31:0] tx_sh_q, tx_sh_d;
`endif

  // Synchronizers and registered sclk edge detect (3 clk pin-to-detection)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      cs_s1_q     <= 1'b1;
      cs_s2_q     <= 1'b1;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      rise_q      <= 1'b0;
    end else begin
      sclk_s1_q   <= sclk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_prev_q <= sclk_s2_q;
      cs_s1_q     <= cs_n;
      cs_s2_q     <= cs_s1_q;
      mosi_s1_q   <= mosi;
      mosi_s2_q   <= mosi_s1_q;
      rise_q      <= sclk_s2_q & ~sclk_prev_q;
    end
  end

  // Frame FSM, counters and strobes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    rx_sh_d = rx_sh_q;
`ifdef SPI_LOADER_READBACK_EN
    re_d       = 1'b0;
    rd_pend_d  = 1'b0;
    shift_ok_d = shift_ok_q;
    tx_sh_d    = tx_sh_q;
    miso_d     = miso_q;
`endif

    // Address advances the clk after each strobe so it is stable during it.
    if (we_q) addr_d = addr_q + ADDR_W'(1);

    if (cs_s2_q) begin
      // cs_n high (or rising mid-word): drop any partial word silently.
      state_d = S_IDLE;
      cnt_d   = 6'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_CMD;
          cnt_d   = 6'd0;
        end
        S_CMD: begin
          if (rise_q) begin
            rx_sh_d = rx_next;
            if (cnt_q == 6'd7) begin
              cmd_d   = rx_next[7:0];
              cnt_d   = 6'd0;
              state_d = S_ADDR;
            end else begin
              cnt_d = cnt_q + 6'd1;
            end
          end
        end
        S_ADDR: begin
          if (rise_q) begin
            rx_sh_d = rx_next;
            if (cnt_q == 6'd15) begin
              addr_d = rx_next[ADDR_W-1:0];
              cnt_d  = 6'd0;
              if (cmd_q == CMD_WRITE) begin
                state_d = S_WDATA;
`ifdef SPI_LOADER_READBACK_EN
              end else if (cmd_q == CMD_READ) begin
                state_d = S_RDATA;
                re_d    = 1'b1;
`endif
              end else begin
                state_d = S_IGNORE;
              end
            end else begin
              cnt_d = cnt_q + 6'd1;
            end
          end
        end
        S_WDATA: begin
          if (rise_q) begin
            rx_sh_d = rx_next;
            if (cnt_q == 6'd31) begin
              we_d    = 1'b1;
              wdata_d = rx_next;
              cnt_d   = 6'd0;
            end else begin
              cnt_d = cnt_q + 6'd1;
            end
          end
        end
`ifdef SPI_LOADER_READBACK_EN
        S_RDATA: begin
          if (rise_q) begin
            shift_ok_d = 1'b1;
            if (cnt_q == 6'd31) begin
              re_d  = 1'b1;
              cnt_d = 6'd0;
            end else begin
              cnt_d = cnt_q + 6'd1;
            end
          end
          // The first falling edge after a load must not shift: the host
          // has not yet sampled the freshly loaded MSB.
          if (fall_q && shift_ok_q) begin
            tx_sh_d = {tx_sh_q[30:0], 1'b0};
            miso_d  = tx_sh_q[30];
          end
        end
`endif
        S_IGNORE: begin
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 6'd0;
        end
      endcase
    end

`ifdef SPI_LOADER_READBACK_EN
    if (re_q) begin
      addr_d    = addr_q + ADDR_W'(1);
      rd_pend_d = 1'b1;
    end
    if (rd_pend_q && !cs_s2_q && state_q == S_RDATA) begin
      tx_sh_d    = mem.mem_rdata;
      miso_d     = mem.mem_rdata[31];
      shift_ok_d = 1'b0;
    end
    if (cs_s2_q || state_q != S_RDATA) miso_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      cmd_q   <= 8'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  // Shift registers carry data only; their contents are qualified by the FSM
  always_ff @(posedge clk) begin
    rx_sh_q <= rx_sh_d;
`ifdef SPI_LOADER_READBACK_EN
    tx_sh_q <= tx_sh_d;
`endif
  end

`ifdef SPI_LOADER_READBACK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fall_q     <= 1'b0;
      re_q       <= 1'b0;
      rd_pend_q  <= 1'b0;
      shift_ok_q <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      fall_q     <= ~sclk_s2_q & sclk_prev_q;
      re_q       <= re_d;
      rd_pend_q  <= rd_pend_d;
      shift_ok_q <= shift_ok_d;
      miso_q     <= miso_d;
    end
  end

  assign mem.mem_re = re_q;
  assign miso       = miso_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^mem.mem_rdata;
  assign mem.mem_re   = 1'b0;
  assign miso         = 1'b0;
`endif

  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_we    = we_q;
  assign cpu_hold      = ~cs_s2_q;

endmodule

// File: tb/tb_spi_mem_loader.sv
`timescale 1ns/1ps
module tb_spi_mem_loader;
  localparam int ADDR_W = 12;
  localparam int HALF   = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic sclk  = 1'b0;
  logic cs_n  = 1'b1;
  logic mosi  = 1'b0;
  logic miso;
  logic cpu_hold;

  always #5 clk = ~clk;

  spi_mem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(32)) mem_bus ();

  spi_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .cpu_hold (cpu_hold),
    .mem      (mem_bus)
  );

  // Memory model: read data appears the clk after mem_re
  logic [31:0] mem_arr [0:4095];
  always @(posedge clk) begin
    if (mem_bus.mem_re) mem_bus.mem_rdata <= mem_arr[mem_bus.mem_addr];
  end

  // Bus monitor, sampled on the falling clk edge
  int we_cnt = 0, re_cnt = 0, we_wide = 0, miso_hi = 0;
  logic we_prev = 1'b0;
  logic [11:0] we_addr [$];
  logic [31:0] we_data [$];
  logic [11:0] re_addr [$];
  always @(negedge clk) begin
    if (mem_bus.mem_we) begin
      we_cnt = we_cnt + 1;
      we_addr.push_back(mem_bus.mem_addr);
      we_data.push_back(mem_bus.mem_wdata);
      if (we_prev) we_wide = we_wide + 1;
    end
    we_prev = mem_bus.mem_we;
    if (mem_bus.mem_re) begin
      re_cnt = re_cnt + 1;
      re_addr.push_back(mem_bus.mem_addr);
    end
    if (miso) miso_hi = miso_hi + 1;
  end

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends command, address and ndata data bits; optionally leaves cs_n low.
  task automatic spi_frame(input logic [7:0] cmd, input logic [15:0] addr,
                           input logic [63:0] data, input int ndata,
                           input bit keep_cs,
                           output logic [63:0] rx, output logic hold_seen);
    logic [87:0] bits;
    bits = {cmd, addr, data};
    rx   = '0;
    cs_n = 1'b0;
    wait_clk(HALF);
    hold_seen = cpu_hold;
    for (int i = 0; i < 24 + ndata; i++) begin
      mosi = bits[87-i];
      wait_clk(HALF);
      sclk = 1'b1;
      if (i >= 24) rx = {rx[62:0], miso};
      wait_clk(HALF);
      sclk = 1'b0;
    end
    wait_clk(HALF);
    if (!keep_cs) cs_n = 1'b1;
    mosi = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [63:0] data;
    int          ndata;
    int          exp_we;
    logic [11:0] exp_a0;
    logic [31:0] exp_d0;
    logic [11:0] exp_a1;
    logic [31:0] exp_d1;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rx;
    logic        hold;
    logic [5:0]  any_out;
    int          b_we, b_re, b_mh;

    for (int i = 0; i < 4096; i++) mem_arr[i] = 32'h0;
    mem_arr[12'h800] = 32'hDEADBEEF;
    mem_arr[12'h801] = 32'h12345678;

    vecs[0] = '{8'h02, 16'h0000, 64'h20080005_2009000A, 64, 2, 12'h000, 32'h20080005, 12'h001, 32'h2009000A};
    vecs[1] = '{8'h02, 16'h0FFF, 64'h11111111_22222222, 64, 2, 12'hFFF, 32'h11111111, 12'h000, 32'h22222222};
    vecs[2] = '{8'h02, 16'h0010, 64'hAAAA5555_0F0F0F0F, 52, 1, 12'h010, 32'hAAAA5555, 12'h000, 32'h0};
    vecs[3] = '{8'h02, 16'h0005, 64'hCAFEF00D_00000000, 32, 1, 12'h005, 32'hCAFEF00D, 12'h000, 32'h0};
    vecs[4] = '{8'h55, 16'h0000, 64'hFFFFFFFF_00000000, 32, 0, 12'h000, 32'h0, 12'h000, 32'h0};
    vecs[5] = '{8'h02, 16'hF123, 64'h13579BDF_00000000, 32, 1, 12'h123, 32'h13579BDF, 12'h000, 32'h0};

    // Reset held while the pins toggle
    any_out = '0;
    wait_clk(3);
    cs_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      mosi = ~mosi;
      sclk = ~sclk;
      wait_clk(HALF);
      any_out = any_out | {mem_bus.mem_we, mem_bus.mem_re, miso, cpu_hold,
                           |mem_bus.mem_addr, |mem_bus.mem_wdata};
    end
    check("reset_outputs_quiet", 64'(any_out), 64'h0);
    check("reset_we_count", 64'(we_cnt), 64'h0);
    check("reset_re_count", 64'(re_cnt), 64'h0);
    sclk = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clk(5);
    reset = 1'b1;
    wait_clk(10);
    check("reset_mem_addr", 64'(mem_bus.mem_addr), 64'h0);
    check("reset_mem_wdata", 64'(mem_bus.mem_wdata), 64'h0);
    check("reset_cpu_hold", 64'(cpu_hold), 64'h0);
    check("reset_miso", 64'(miso), 64'h0);

    // Directed write / ignore frames
    for (int v = 0; v < 6; v++) begin
      b_we = we_cnt;
      b_re = re_cnt;
      b_mh = miso_hi;
      spi_frame(vecs[v].cmd, vecs[v].addr, vecs[v].data, vecs[v].ndata, 1'b0, rx, hold);
      wait_clk(6);
      check($sformatf("v%0d_hold_in_frame", v), 64'(hold), 64'h1);
      check($sformatf("v%0d_hold_after", v), 64'(cpu_hold), 64'h0);
      check($sformatf("v%0d_we_count", v), 64'(we_cnt - b_we), 64'(vecs[v].exp_we));
      if (vecs[v].exp_we >= 1 && we_cnt > b_we) begin
        check($sformatf("v%0d_addr0", v), 64'(we_addr[b_we]), 64'(vecs[v].exp_a0));
        check($sformatf("v%0d_data0", v), 64'(we_data[b_we]), 64'(vecs[v].exp_d0));
      end
      if (vecs[v].exp_we >= 2 && we_cnt > b_we + 1) begin
        check($sformatf("v%0d_addr1", v), 64'(we_addr[b_we+1]), 64'(vecs[v].exp_a1));
        check($sformatf("v%0d_data1", v), 64'(we_data[b_we+1]), 64'(vecs[v].exp_d1));
      end
      check($sformatf("v%0d_re_count", v), 64'(re_cnt - b_re), 64'h0);
      check($sformatf("v%0d_miso_quiet", v), 64'(miso_hi - b_mh), 64'h0);
      wait_clk(10);
    end

    // Reset asserted mid-word: no partial write, immediate idle
    b_we = we_cnt;
    spi_frame(8'h02, 16'h0040, 64'h76543210_00000000, 20, 1'b1, rx, hold);
    check("midreset_hold_before", 64'(cpu_hold), 64'h1);
    reset = 1'b0;
    #1;
    check("midreset_hold_async", 64'(cpu_hold), 64'h0);
    check("midreset_addr_async", 64'(mem_bus.mem_addr), 64'h0);
    wait_clk(3);
    cs_n = 1'b1;
    wait_clk(3);
    reset = 1'b1;
    wait_clk(10);
    check("midreset_no_write", 64'(we_cnt - b_we), 64'h0);

    // Read frame
    b_we = we_cnt;
    b_re = re_cnt;
    b_mh = miso_hi;
    spi_frame(8'h03, 16'h0800, 64'h0, 64, 1'b0, rx, hold);
    wait_clk(6);
    check("read_no_write", 64'(we_cnt - b_we), 64'h0);
    check("read_miso_idle_after", 64'(miso), 64'h0);
`ifdef SPI_LOADER_READBACK_EN
    check("read_stream", rx, 64'hDEADBEEF_12345678);
    check("read_re_count", 64'(re_cnt - b_re), 64'h3);
    if (re_cnt >= b_re + 2) begin
      check("read_re_addr0", 64'(re_addr[b_re]), 64'h800);
      check("read_re_addr1", 64'(re_addr[b_re+1]), 64'h801);
    end
`else
    check("read_disabled_stream", rx, 64'h0);
    check("read_disabled_re_count", 64'(re_cnt - b_re), 64'h0);
    check("read_disabled_miso", 64'(miso_hi - b_mh), 64'h0);
`endif
    wait_clk(10);

    // Recovery write after everything above
    b_we = we_cnt;
    spi_frame(8'h02, 16'h0002, 64'h0BADC0DE_00000000, 32, 1'b0, rx, hold);
    wait_clk(6);
    check("final_we_count", 64'(we_cnt - b_we), 64'h1);
    if (we_cnt > b_we) begin
      check("final_addr", 64'(we_addr[b_we]), 64'h002);
      check("final_data", 64'(we_data[b_we]), 64'h0BADC0DE);
    end

    check("we_pulse_width", 64'(we_wide), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
